bank_timing_guard: RTL and testbench

Per-bank DRAM timing guard between a bank_FSM instance and the channel command bus. It watches the bank's `ba_state`/`ba_issue`/`ba_addr`, and drives the bank's `stall` input to hold the FSM whenever the requested command would break a DRAM timing constraint. When the command is legal it issues exactly one registered DRAM command. It also inserts the precharge a refresh needs when the bank still has a row open.

---
 rtl/bank_timing_guard.sv | 198 +++++++++++++++++++
 tb/tb_bank_timing_guard.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_timing_guard.sv
// Per-bank DRAM timing guard: holds the bank FSM until its requested command meets
// the DRAM timing rules, issues one registered command, and inserts the PRE a REF needs.
package bank_timing_guard_pkg;
    localparam int unsigned FSM_WIDTH2 = 3;
    localparam int unsigned ADDR_BITS  = 14;

    typedef enum logic [FSM_WIDTH2-1:0] {
        B_IDLE          = 3'd0,
        B_ACTIVE        = 3'd1,
        B_READ          = 3'd2,
        B_WRITE         = 3'd3,
        B_PRE           = 3'd4,
        B_ISSUE_REFRESH = 3'd5,
        B_ROW_OPEN      = 3'd6,
        B_REFRESH       = 3'd7
    } bank_state_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_code_t;

    typedef enum logic {
        G_IDLE     = 1'b0,
        G_AUTO_PRE = 1'b1
    } guard_state_t;
endpackage

module bank_timing_guard
    import bank_timing_guard_pkg::*;
#(
    parameter int unsigned T_RCD = 4,
    parameter int unsigned T_RP  = 4,
    parameter int unsigned T_RAS = 10,
    parameter int unsigned T_RTP = 3,
    parameter int unsigned T_WTP = 8,
    parameter int unsigned T_CCD = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  bank_state_t          ba_state,
    input  logic                 ba_issue,
    input  logic [ADDR_BITS-1:0] ba_addr,
    input  logic                 ext_stall,
    output logic                 stall,
    output logic                 cmd_valid,
    output logic [2:0]           cmd_code,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic                 row_open,
    output logic                 proto_err
);

    guard_state_t          gstate, gstate_nx;
    logic [CNT_W-1:0]      since_act, since_pre, since_rd, since_wr, since_cas;
    logic                  issue;
    cmd_code_t             issue_code;
    logic [ADDR_BITS-1:0]  issue_addr;
    logic                  err_hit;
    logic                  act_ok, cas_ok, pre_ok, ref_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Timing legality of each command against the elapsed counters
    assign act_ok = !row_open && (since_pre >= CNT_W'(T_RP));
    assign cas_ok = row_open && (since_act >= CNT_W'(T_RCD)) && (since_cas >= CNT_W'(T_CCD));
    assign pre_ok = (since_act >= CNT_W'(T_RAS)) && (since_rd >= CNT_W'(T_RTP))
                    && (since_wr >= CNT_W'(T_WTP));
    assign ref_ok = !row_open && (since_pre >= CNT_W'(T_RP));

    // Request decode, stall generation and guard sub-FSM next state
    always_comb begin
        stall      = 1'b0;
        issue      = 1'b0;
        issue_code = CMD_NOP;
        issue_addr = '0;
        err_hit    = 1'b0;
        gstate_nx  = gstate;

        if (!ba_issue) begin
            gstate_nx = G_IDLE;
        end else if (gstate == G_AUTO_PRE) begin
            if (ba_state == B_ISSUE_REFRESH) begin
                if (ref_ok && !ext_stall) begin
                    issue      = 1'b1;
                    issue_code = CMD_REF;
                    gstate_nx  = G_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end else begin
                // Unexpected request change while refreshing: abandon, re-decode next cycle
                stall     = 1'b1;
                gstate_nx = G_IDLE;
            end
        end else begin
            case (ba_state)
                B_ACTIVE: begin
                    if (row_open) begin
                        if (ext_stall) stall = 1'b1;
                        else           err_hit = 1'b1;
                    end else if (act_ok && !ext_stall) begin
                        issue      = 1'b1;
                        issue_code = CMD_ACT;
                        issue_addr = ba_addr;
                    end else begin
                        stall = 1'b1;
                    end
                end
                B_READ, B_WRITE: begin
                    if (!row_open) begin
                        if (ext_stall) stall = 1'b1;
                        else           err_hit = 1'b1;
                    end else if (cas_ok && !ext_stall) begin
                        issue      = 1'b1;
                        issue_code = (ba_state == B_READ) ? CMD_RD : CMD_WR;
                        issue_addr = ba_addr;
                    end else begin
                        stall = 1'b1;
                    end
                end
                B_PRE: begin
                    if (pre_ok && !ext_stall) begin
                        issue      = 1'b1;
                        issue_code = CMD_PRE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                B_ISSUE_REFRESH: begin
                    if (row_open) begin
                        stall = 1'b1;
                        if (pre_ok && !ext_stall) begin
                            issue      = 1'b1;
                            issue_code = CMD_PRE;
                            gstate_nx  = G_AUTO_PRE;
                        end
                    end else if (ref_ok && !ext_stall) begin
                        issue      = 1'b1;
                        issue_code = CMD_REF;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered command bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gstate    <= G_IDLE;
            since_act <= '1;
            since_pre <= '1;
            since_rd  <= '1;
            since_wr  <= '1;
            since_cas <= '1;
            cmd_valid <= 1'b0;
            cmd_code  <= 3'(CMD_NOP);
            cmd_addr  <= '0;
            row_open  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            gstate    <= gstate_nx;
            since_act <= (issue && issue_code == CMD_ACT) ? CNT_W'(1) : sat_inc(since_act);
            since_pre <= (issue && issue_code == CMD_PRE) ? CNT_W'(1) : sat_inc(since_pre);
            since_rd  <= (issue && issue_code == CMD_RD)  ? CNT_W'(1) : sat_inc(since_rd);
            since_wr  <= (issue && issue_code == CMD_WR)  ? CNT_W'(1) : sat_inc(since_wr);
            since_cas <= (issue && (issue_code == CMD_RD || issue_code == CMD_WR))
                         ? CNT_W'(1) : sat_inc(since_cas);
            cmd_valid <= issue;
            if (issue) begin
                cmd_code <= 3'(issue_code);
                cmd_addr <= issue_addr;
            end else begin
                cmd_code <= 3'(CMD_NOP);
            end
            if (issue && issue_code == CMD_ACT) begin
                row_open <= 1'b1;
            end else if (issue && (issue_code == CMD_PRE || issue_code == CMD_REF)) begin
                row_open <= 1'b0;
            end
            if (err_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bank_timing_guard.sv
// Directed bench for bank_timing_guard: timestamp-based reference model checked every
// cycle, plus hand-computed issue cycles and command logs for the key scenarios.
module tb_bank_timing_guard;
    import bank_timing_guard_pkg::*;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RAS = 10;
    localparam int T_RTP = 3;
    localparam int T_WTP = 8;
    localparam int T_CCD = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    bank_state_t          ba_state = B_IDLE;
    logic                 ba_issue = 1'b0;
    logic [ADDR_BITS-1:0] ba_addr = '0;
    logic                 ext_stall = 1'b0;
    logic                 stall;
    logic                 cmd_valid;
    logic [2:0]           cmd_code;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic                 row_open;
    logic                 proto_err;

    bank_timing_guard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ba_state  (ba_state),
        .ba_issue  (ba_issue),
        .ba_addr   (ba_addr),
        .ext_stall (ext_stall),
        .stall     (stall),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_addr  (cmd_addr),
        .row_open  (row_open),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int log_cyc[$];
    int log_code[$];
    int log_addr[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: last-issue timestamps and the expected registered outputs
    int  last_act, last_pre, last_rd, last_wr, last_cas;
    bit  exp_valid, exp_open, exp_err, m_auto;
    int  exp_code, exp_addr;

    always @(negedge clk) begin : monitor
        int  el_act, el_pre, el_rd, el_wr, el_cas;
        bit  m_stall, m_issue, m_err, new_auto;
        int  m_code, m_addr;
        bit  pre_rule, ref_rule;
        if (!rst_n) begin
            last_act = -1000; last_pre = -1000; last_rd = -1000;
            last_wr  = -1000; last_cas = -1000;
            exp_valid = 0; exp_open = 0; exp_err = 0; m_auto = 0;
            exp_code = 0; exp_addr = 0;
            check("rst_cmd_valid", cmd_valid, 0);
            check("rst_cmd_code", cmd_code, 0);
            check("rst_cmd_addr", cmd_addr, 0);
            check("rst_row_open", row_open, 0);
            check("rst_proto_err", proto_err, 0);
            check("rst_stall", stall, 0);
        end else begin
            check("cmd_valid", cmd_valid, exp_valid);
            check("cmd_code", cmd_code, exp_code);
            check("cmd_addr", cmd_addr, exp_addr);
            check("row_open", row_open, exp_open);
            check("proto_err", proto_err, exp_err);
            if (cmd_valid) begin
                log_cyc.push_back(cyc);
                log_code.push_back(int'(cmd_code));
                log_addr.push_back(int'(cmd_addr));
            end

            el_act = cyc - last_act; el_pre = cyc - last_pre; el_rd = cyc - last_rd;
            el_wr  = cyc - last_wr;  el_cas = cyc - last_cas;
            pre_rule = (el_act >= T_RAS) && (el_rd >= T_RTP) && (el_wr >= T_WTP);
            ref_rule = !exp_open && (el_pre >= T_RP);
            m_stall = 0; m_issue = 0; m_err = 0; new_auto = 0; m_code = 0; m_addr = 0;

            if (ba_issue && m_auto) begin
                if (ba_state == B_ISSUE_REFRESH) begin
                    if (ref_rule && !ext_stall) begin m_issue = 1; m_code = 5; end
                    else begin m_stall = 1; new_auto = 1; end
                end else begin
                    m_stall = 1;
                end
            end else if (ba_issue) begin
                case (ba_state)
                    B_ACTIVE:
                        if (exp_open) m_err = 1;
                        else if (el_pre >= T_RP && !ext_stall) begin
                            m_issue = 1; m_code = 1; m_addr = int'(ba_addr);
                        end else m_stall = 1;
                    B_READ, B_WRITE:
                        if (!exp_open) m_err = 1;
                        else if (el_act >= T_RCD && el_cas >= T_CCD && !ext_stall) begin
                            m_issue = 1; m_code = (ba_state == B_READ) ? 2 : 3;
                            m_addr = int'(ba_addr);
                        end else m_stall = 1;
                    B_PRE:
                        if (pre_rule && !ext_stall) begin m_issue = 1; m_code = 4; end
                        else m_stall = 1;
                    B_ISSUE_REFRESH:
                        if (exp_open) begin
                            m_stall = 1;
                            if (pre_rule && !ext_stall) begin
                                m_issue = 1; m_code = 4; new_auto = 1;
                            end
                        end else if (ref_rule && !ext_stall) begin
                            m_issue = 1; m_code = 5;
                        end else m_stall = 1;
                    default: ;
                endcase
            end
            if (m_err) begin
                if (ext_stall) m_stall = 1;
                else           exp_err = 1;
            end
            check("stall", stall, m_stall);

            exp_valid = m_issue;
            exp_code  = m_issue ? m_code : 0;
            if (m_issue) exp_addr = m_addr;
            if (m_issue) begin
                case (m_code)
                    1: begin last_act = cyc; exp_open = 1; end
                    2: begin last_rd = cyc; last_cas = cyc; end
                    3: begin last_wr = cyc; last_cas = cyc; end
                    4: begin last_pre = cyc; exp_open = 0; end
                    default: exp_open = 0;
                endcase
            end
            m_auto = new_auto;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; ba_issue = 1'b0; ext_stall = 1'b0; ba_state = B_IDLE;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_cyc.delete(); log_code.delete(); log_addr.delete();
    endtask

    // Hold a request until the guard releases the bank; returns the issue cycle
    task automatic req(input bank_state_t st, input logic [ADDR_BITS-1:0] a, output int ic);
        bit done = 0;
        ic = -1;
        ba_issue = 1'b1; ba_state = st; ba_addr = a;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin ic = cyc; done = 1; end
        end
        check("req_timeout", done, 1);
        @(posedge clk); #1;
        ba_issue = 1'b0; ba_state = B_IDLE;
    endtask

    task automatic chk_log(input int idx, input int c, input int code, input int addr);
        if (log_cyc.size() > idx) begin
            check("log_cycle", log_cyc[idx], c);
            check("log_code", log_code[idx], code);
            check("log_addr", log_addr[idx], addr);
        end else begin
            check("log_missing", log_cyc.size(), idx + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ic, r;
        do_reset();
        check("post_reset_stall", stall, 0);
        check("post_reset_row_open", row_open, 0);

        // ACT then back-to-back reads
        req(B_ACTIVE, 14'h12, ic);  check("act_issue", ic, 0);
        req(B_READ, 14'h5, ic);     check("rd1_issue", ic, 4);
        req(B_READ, 14'h6, ic);     check("rd2_issue", ic, 6);
        idle(1);
        check("rd_log_size", log_cyc.size(), 3);
        chk_log(0, 1, 1, 'h12);
        chk_log(1, 5, 2, 'h5);
        chk_log(2, 7, 2, 'h6);
        check("rd_row_open", row_open, 1);

        // Write-to-precharge, then precharge-to-activate
        do_reset();
        req(B_ACTIVE, 14'h20, ic);  check("act2_issue", ic, 0);
        idle(3);
        req(B_WRITE, 14'h7, ic);    check("wr_issue", ic, 4);
        req(B_PRE, 14'h0, ic);      check("pre_issue", ic, 12);
        req(B_ACTIVE, 14'h33, ic);  check("act3_issue", ic, 16);

        // Refresh with an open row: implicit PRE then REF
        idle(12);
        r = cyc;
        log_cyc.delete(); log_code.delete(); log_addr.delete();
        req(B_ISSUE_REFRESH, 14'h0, ic);
        check("ref_issue", ic, r + 4);
        idle(1);
        check("ref_log_size", log_cyc.size(), 2);
        chk_log(0, r + 1, 4, 0);
        chk_log(1, r + 5, 5, 0);
        check("ref_row_open", row_open, 0);

        // ext_stall holds a legal read
        do_reset();
        req(B_ACTIVE, 14'h40, ic);
        idle(4);
        ext_stall = 1'b1; ba_issue = 1'b1; ba_state = B_READ; ba_addr = 14'h9;
        idle(3);
        check("ext_log_size", log_cyc.size(), 1);
        ext_stall = 1'b0;
        req(B_READ, 14'h9, ic);     check("ext_rd_issue", ic, 8);
        idle(1);
        chk_log(1, 9, 2, 'h9);

        // Counter saturation: long idle keeps every constraint met
        do_reset();
        req(B_ACTIVE, 14'h1, ic);
        idle(300);
        req(B_WRITE, 14'h2, ic);    check("sat_wr_issue", ic, 301);
        idle(300);
        req(B_PRE, 14'h0, ic);      check("sat_pre_issue", ic, 602);

        // Protocol errors and async clear
        do_reset();
        req(B_READ, 14'h3, ic);     check("err_rd_release", ic, 0);
        idle(1);
        check("err_flag", proto_err, 1);
        check("err_no_cmd", log_cyc.size(), 0);
        req(B_ACTIVE, 14'h4, ic);   check("err_act_issue", ic, 2);
        req(B_ACTIVE, 14'h5, ic);   check("err_act2_release", ic, 3);
        idle(4);
        check("err_log_size", log_cyc.size(), 1);
        check("err_sticky", proto_err, 1);
        #2 rst_n = 1'b0;
        #1 check("err_async_clear", proto_err, 0);
        check("err_async_row", row_open, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while the implicit precharge is pending
        do_reset();
        req(B_ACTIVE, 14'h7, ic);
        idle(11);
        ba_issue = 1'b1; ba_state = B_ISSUE_REFRESH;
        idle(1);
        check("auto_pre_valid", cmd_valid, 1);
        check("auto_pre_code", cmd_code, 4);
        #1 rst_n = 1'b0; ba_issue = 1'b0; ba_state = B_IDLE;
        #1 check("auto_rst_valid", cmd_valid, 0);
        check("auto_rst_code", cmd_code, 0);
        check("auto_rst_row", row_open, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        log_cyc.delete(); log_code.delete(); log_addr.delete();
        req(B_ISSUE_REFRESH, 14'h0, ic);
        check("post_rst_ref_issue", ic, 0);
        idle(2);
        check("post_rst_ref_log", log_cyc.size(), 1);
        chk_log(0, 1, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
